// File: rtl/serial_frame_pkg.sv
// Shared definitions for the serial frame transmitter and its matching receiver.
// Holds the frame FSM states, the parity-mode constants and a parity helper.
package serial_frame_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } frame_state_e;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_EVEN = 1;

    // Even-parity bit: XOR of all payload bits, zero-extended to 16 bits.
    function automatic logic even_parity16(input logic [15:0] i_v);
        return ^i_v;
    endfunction

endpackage

// File: rtl/serial_baud_cnt.sv
// Bit-period down-counter: loads DIV-1, counts down to 0 and holds there.
// o_tc is high while the count reads 0, marking the last cycle of a bit period.
module serial_baud_cnt #(
    parameter int unsigned DIV = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load,
    output logic o_tc
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= LOAD_VAL;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, LSB-first payload, optional even parity, 1-2 stop bits.
// Line and busy are registered from next-state so they change on the same edge as the FSM.
module serial_frame_tx
    import serial_frame_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DIV       = 16,
    parameter int unsigned PARITY_EN = PARITY_EVEN,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic              b,
    input  logic              c,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              o,
    output logic              busy
);

    localparam int unsigned IW = $clog2(DATA_W + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);
    localparam logic STOP_LAST = (STOP_BITS == 2);

    frame_state_e      r_state, w_state_d;
    logic [DATA_W-1:0] r_shift, w_shift_d;
    logic [IW-1:0]     r_idx, w_idx_d;
    logic              r_stop_idx, w_stop_idx_d;
    logic              r_parity, w_parity_d;
    logic              r_o, w_o_d;
    logic              r_busy;
    logic              w_load;
    logic              w_tc;

    serial_baud_cnt #(
        .DIV(DIV)
    ) u_baud (
        .i_clk  (b),
        .i_rst_n(c),
        .i_load (w_load),
        .o_tc   (w_tc)
    );

    assign tx_ready = (r_state == IDLE);

    always_comb begin
        w_state_d    = r_state;
        w_shift_d    = r_shift;
        w_idx_d      = r_idx;
        w_stop_idx_d = r_stop_idx;
        w_parity_d   = r_parity;
        w_load       = 1'b0;
        w_o_d        = 1'b1;

        unique case (r_state)
            IDLE: begin
                if (tx_valid) begin
                    w_state_d    = START;
                    w_shift_d    = tx_data;
                    w_parity_d   = even_parity16(16'(tx_data));
                    w_idx_d      = '0;
                    w_stop_idx_d = 1'b0;
                    w_load       = 1'b1;
                end
            end
            START: begin
                if (w_tc) begin
                    w_state_d = DATA;
                    w_load    = 1'b1;
                end
            end
            DATA: begin
                if (w_tc) begin
                    w_load = 1'b1;
                    if (r_idx == LAST_IDX) begin
                        w_idx_d   = '0;
                        w_state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        w_idx_d   = r_idx + IW'(1);
                        w_shift_d = r_shift >> 1;
                    end
                end
            end
            PARITY: begin
                if (w_tc) begin
                    w_state_d = STOP;
                    w_load    = 1'b1;
                end
            end
            STOP: begin
                if (w_tc) begin
                    if (r_stop_idx == STOP_LAST) begin
                        w_state_d = IDLE;
                    end else begin
                        w_stop_idx_d = 1'b1;
                        w_load       = 1'b1;
                    end
                end
            end
            default: w_state_d = IDLE;
        endcase

        // Line value follows the state being entered, so o is aligned with the FSM.
        unique case (w_state_d)
            IDLE:    w_o_d = 1'b1;
            START:   w_o_d = 1'b0;
            DATA:    w_o_d = w_shift_d[0];
            PARITY:  w_o_d = w_parity_d;
            STOP:    w_o_d = 1'b1;
            default: w_o_d = 1'b1;
        endcase
    end

    always_ff @(posedge b or negedge c) begin
        if (!c) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_idx      <= '0;
            r_stop_idx <= 1'b0;
            r_parity   <= 1'b0;
            r_o        <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_shift    <= w_shift_d;
            r_idx      <= w_idx_d;
            r_stop_idx <= w_stop_idx_d;
            r_parity   <= w_parity_d;
            r_o        <= w_o_d;
            r_busy     <= (w_state_d != IDLE);
        end
    end

    assign o    = r_o;
    assign busy = r_busy;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Scoreboard bench for serial_frame_tx: three parameterisations, expected per-cycle line
// waveforms are queued at stimulus time and a negedge monitor compares each captured frame.
module tb_serial_frame_tx;

    typedef struct {
        int          inst;
        logic [63:0] vec;
        int          len;
        int          gap;
    } frame_t;

    logic       b;
    logic [2:0] c;
    logic [2:0] v;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       d2;
    logic [2:0] rdy;
    logic [2:0] o_w;
    logic [2:0] busy_w;

    int n_checks = 0;
    int n_errors = 0;

    frame_t exp_q[$];

    serial_frame_tx #(.DATA_W(8), .DIV(4), .PARITY_EN(1), .STOP_BITS(1)) u_dut0 (
        .b(b), .c(c[0]), .tx_data(d0), .tx_valid(v[0]),
        .tx_ready(rdy[0]), .o(o_w[0]), .busy(busy_w[0])
    );

    serial_frame_tx #(.DATA_W(8), .DIV(2), .PARITY_EN(0), .STOP_BITS(2)) u_dut1 (
        .b(b), .c(c[1]), .tx_data(d1), .tx_valid(v[1]),
        .tx_ready(rdy[1]), .o(o_w[1]), .busy(busy_w[1])
    );

    serial_frame_tx #(.DATA_W(1), .DIV(2), .PARITY_EN(1), .STOP_BITS(1)) u_dut2 (
        .b(b), .c(c[2]), .tx_data(d2), .tx_valid(v[2]),
        .tx_ready(rdy[2]), .o(o_w[2]), .busy(busy_w[2])
    );

    initial begin
        b = 1'b0;
        forever #5 b = ~b;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Bit string is written in transmit order; each character is held for div cycles.
    function automatic frame_t mk(input int k, input string bits, input int div, input int gap);
        frame_t f;
        f.inst = k;
        f.vec  = '0;
        f.len  = 0;
        f.gap  = gap;
        for (int i = 0; i < bits.len(); i++) begin
            for (int j = 0; j < div; j++) begin
                f.vec[f.len] = (bits[i] == 8'h31);
                f.len++;
            end
        end
        return f;
    endfunction

    task automatic set_data(input int k, input logic [7:0] data);
        case (k)
            0:       d0 = data;
            1:       d1 = data;
            default: d2 = data[0];
        endcase
    endtask

    task automatic wait_ready(input int k);
        int n;
        n = 0;
        while (!rdy[k] && n < 300) begin
            @(posedge b);
            #1;
            n++;
        end
        chk("ready_wait", int'(rdy[k]), 1);
    endtask

    task automatic send(input int k, input logic [7:0] data);
        set_data(k, data);
        v[k] = 1'b1;
        wait_ready(k);
        @(posedge b);
        #1;
        v[k] = 1'b0;
        chk("accept_busy", int'(busy_w[k]), 1);
        chk("accept_o", int'(o_w[k]), 0);
        chk("accept_rdy", int'(rdy[k]), 0);
    endtask

    // Monitor: captures the line for every busy stretch and compares it to the queue head.
    initial begin
        logic [63:0] cap_vec[3];
        int          cap_len[3];
        int          idle_len[3];
        int          idle_at_start[3];
        frame_t      f;
        for (int k = 0; k < 3; k++) begin
            cap_vec[k]       = '0;
            cap_len[k]       = 0;
            idle_len[k]      = 0;
            idle_at_start[k] = 0;
        end
        forever begin
            @(negedge b);
            for (int k = 0; k < 3; k++) begin
                chk("rdy_vs_busy", int'(rdy[k]), int'(!busy_w[k]));
                if (busy_w[k]) begin
                    if (cap_len[k] == 0) begin
                        cap_vec[k]       = '0;
                        idle_at_start[k] = idle_len[k];
                    end
                    if (cap_len[k] < 64) cap_vec[k][cap_len[k]] = o_w[k];
                    cap_len[k]++;
                    idle_len[k] = 0;
                end else begin
                    chk("idle_o", int'(o_w[k]), 1);
                    if (cap_len[k] != 0) begin
                        if (exp_q.size() == 0) begin
                            n_checks++;
                            n_errors++;
                            $display("FAIL unexpected_frame inst=%0d len=%0d", k, cap_len[k]);
                        end else begin
                            f = exp_q.pop_front();
                            chk("frame_inst", k, f.inst);
                            chk("frame_len", cap_len[k], f.len);
                            chk64("frame_bits", cap_vec[k], f.vec);
                            if (f.gap >= 0) chk("frame_gap", idle_at_start[k], f.gap);
                        end
                        cap_len[k] = 0;
                    end
                    idle_len[k]++;
                end
            end
        end
    end

    initial begin
        int n;
        c  = 3'b000;
        v  = 3'b000;
        d0 = 8'h00;
        d1 = 8'h00;
        d2 = 1'b0;

        repeat (2) @(posedge b);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_o", int'(o_w[k]), 1);
            chk("rst_busy", int'(busy_w[k]), 0);
            chk("rst_rdy", int'(rdy[k]), 1);
        end
        @(negedge b);
        c = 3'b111;

        // 0xA5: start, 1,0,1,0,0,1,0,1, parity 0, stop -> 44 busy cycles
        exp_q.push_back(mk(0, "01010010101", 4, -1));
        send(0, 8'hA5);
        wait_ready(0);

        // valid held high: 0x01 (parity 1) then 0xFF (parity 0), one idle cycle between
        exp_q.push_back(mk(0, "01000000011", 4, -1));
        exp_q.push_back(mk(0, "01111111101", 4, 1));
        d0   = 8'h01;
        v[0] = 1'b1;
        wait_ready(0);
        @(posedge b);
        #1;
        chk("b2b_first_busy", int'(busy_w[0]), 1);
        d0 = 8'hFF;
        wait_ready(0);
        @(posedge b);
        #1;
        v[0] = 1'b0;
        chk("b2b_second_busy", int'(busy_w[0]), 1);
        chk("b2b_second_o", int'(o_w[0]), 0);
        wait_ready(0);

        // Abort during cycle 10: start (4 cycles 0), bit0=1 (4 cycles), bit1=0 (2 cycles)
        exp_q.push_back(mk(0, "0000111100", 1, -1));
        send(0, 8'hA5);
        repeat (10) @(posedge b);
        #2;
        c[0] = 1'b0;
        #1;
        chk("abort_o", int'(o_w[0]), 1);
        chk("abort_busy", int'(busy_w[0]), 0);
        chk("abort_rdy", int'(rdy[0]), 1);
        repeat (2) @(posedge b);
        #1;
        chk("abort_hold_o", int'(o_w[0]), 1);

        // Accept on the first edge after release; payload changes mid-DATA are ignored
        exp_q.push_back(mk(0, "00011110001", 4, -1));
        #2;
        c[0] = 1'b1;
        d0   = 8'h3C;
        v[0] = 1'b1;
        @(posedge b);
        #1;
        v[0] = 1'b0;
        chk("release_accept_busy", int'(busy_w[0]), 1);
        chk("release_accept_o", int'(o_w[0]), 0);
        repeat (20) @(posedge b);
        #1;
        d0 = 8'hC3;
        wait_ready(0);

        // No parity, two stop bits, DIV=2, 0x00 -> 22 cycles, ready on cycle 22
        exp_q.push_back(mk(1, "00000000011", 2, -1));
        send(1, 8'h00);
        repeat (21) @(posedge b);
        #1;
        chk("stop2_last_rdy", int'(rdy[1]), 0);
        chk("stop2_last_o", int'(o_w[1]), 1);
        @(posedge b);
        #1;
        chk("stop2_after_rdy", int'(rdy[1]), 1);
        chk("stop2_after_busy", int'(busy_w[1]), 0);

        // Single-bit payload at the minimum divider
        exp_q.push_back(mk(2, "0111", 2, -1));
        send(2, 8'h01);
        wait_ready(2);
        exp_q.push_back(mk(2, "0001", 2, -1));
        send(2, 8'h00);
        wait_ready(2);

        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge b);
            n++;
        end
        repeat (3) @(posedge b);
        chk("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
